// File: rtl/axis_insert_hdr_pkg.sv
// Shared types and byte-count helpers for the header-insert datapath.
package axis_insert_hdr_pkg;

    // Widest beat the helpers support, in bytes; callers slice the result.
    localparam int MAX_BYTES = 64;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    // Number of set bits in an MSB-aligned byte-enable vector.
    function automatic int keep2cnt(input logic [MAX_BYTES-1:0] keep);
        int n;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (keep[i]) n++;
        end
        return n;
    endfunction

    // Byte-enable vector with the top cnt of nbytes lanes set.
    function automatic logic [MAX_BYTES-1:0] cnt2keep_msb(input int cnt, input int nbytes);
        logic [MAX_BYTES-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < nbytes && i >= nbytes - cnt) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_insert_hdr_if.sv
// Payload, header and output channels of the header-insert block.
// slave: the block's view; master: the view of whatever drives it.
interface axis_insert_hdr_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic                    ready_insert;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        output ready_in,
        output valid_out, data_out, keep_out, last_out,
        input  ready_out,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_insert
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        input  ready_in,
        input  valid_out, data_out, keep_out, last_out,
        output ready_out,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_insert
    );
endinterface

// File: rtl/axis_insert_hdr_out_reg.sv
// Valid/ready register slice for the output beat (data, keep, last).
// Loads a new beat in the same cycle the held one is consumed.
module axis_insert_hdr_out_reg #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WD-1:0]      in_data,
    input  logic [DATA_BYTE_WD-1:0] in_keep,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WD-1:0]      out_data,
    output logic [DATA_BYTE_WD-1:0] out_keep,
    output logic                    out_last,
    input  logic                    out_ready
);
    logic                    vld_p1;
    logic [DATA_WD-1:0]      data_p1;
    logic [DATA_BYTE_WD-1:0] keep_p1;
    logic                    last_p1;

    assign in_ready = !vld_p1 || out_ready;

    // Stage p1: capture the formed beat whenever the slot is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            keep_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                data_p1 <= in_data;
                keep_p1 <= in_keep;
                last_p1 <= in_last;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_keep  = keep_p1;
    assign out_last  = last_p1;
endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends a 1..DATA_BYTE_WD byte header to each AXI-Stream packet and
// re-packs header plus payload into full big-endian beats.
// Optional macro AXIS_INSERT_HDR_ASSERT_EN compiles protocol assertions.
module axi_stream_insert_header
    import axis_insert_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic             clk,
    input logic             rst,
    axis_insert_hdr_if.slave bus
);
    // Counts up to two beats' worth of bytes (header + last payload).
    localparam int CNT_W = BYTE_CNT_WD + 2;
    localparam logic [CNT_W-1:0] NB_C = CNT_W'(DATA_BYTE_WD);

    state_t                  state;
    logic                    hdr_rdy;
    logic [DATA_WD-1:0]      carry;     // pending bytes, LSB-aligned
    logic [CNT_W-1:0]        h_len;     // header length H
    logic [CNT_W-1:0]        rem_len;   // residue bytes for FLUSH
    logic [CNT_W-1:0]        total;
    int                      sh_c;
    int                      sh_d;
    logic [DATA_WD-1:0]      merged;
    logic [MAX_BYTES-1:0]    keep_w;
    logic                    beat_vld;
    logic [DATA_WD-1:0]      beat_data;
    logic [DATA_BYTE_WD-1:0] beat_keep;
    logic                    beat_last;
    logic                    slot_rdy;
    logic                    unused_keep_hi;

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    assign bus.ready_insert = hdr_rdy;
    assign bus.ready_in     = (state == STREAM) && slot_rdy;
    assign unused_keep_hi   = ^keep_w[MAX_BYTES-1:DATA_BYTE_WD];

    // Form the next output beat: carry bytes on top, fresh payload below.
    always_comb begin
        total     = h_len + CNT_W'(keep2cnt(MAX_BYTES'(bus.keep_in)));
        sh_c      = (DATA_BYTE_WD - int'(h_len)) * 8;
        sh_d      = int'(h_len) * 8;
        merged    = (carry << sh_c) | (bus.data_in >> sh_d);
        keep_w    = '0;
        beat_vld  = 1'b0;
        beat_data = '0;
        beat_keep = '0;
        beat_last = 1'b0;
        case (state)
            STREAM: begin
                if (bus.valid_in) begin
                    beat_vld = 1'b1;
                    if (bus.last_in && total <= NB_C) begin
                        keep_w    = cnt2keep_msb(int'(total), DATA_BYTE_WD);
                        beat_keep = keep_w[DATA_BYTE_WD-1:0];
                        beat_data = merged & byte_mask(beat_keep);
                        beat_last = 1'b1;
                    end else begin
                        beat_keep = '1;
                        beat_data = merged;
                    end
                end
            end
            FLUSH: begin
                beat_vld  = 1'b1;
                keep_w    = cnt2keep_msb(int'(rem_len), DATA_BYTE_WD);
                beat_keep = keep_w[DATA_BYTE_WD-1:0];
                beat_data = (carry << sh_c) & byte_mask(beat_keep);
                beat_last = 1'b1;
            end
            default: ;
        endcase
    end

    // Packet sequencing: take a header, stream payload, emit any residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hdr_rdy <= 1'b0;
            carry   <= '0;
            h_len   <= '0;
            rem_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_insert && hdr_rdy) begin
                        carry   <= bus.data_insert & byte_mask(bus.keep_insert);
                        h_len   <= (bus.byte_insert_cnt == '0) ? NB_C : CNT_W'(bus.byte_insert_cnt);
                        hdr_rdy <= 1'b0;
                        state   <= STREAM;
                    end else begin
                        hdr_rdy <= 1'b1;
                    end
                end
                STREAM: begin
                    if (bus.valid_in && slot_rdy) begin
                        carry <= bus.data_in;
                        if (bus.last_in) begin
                            if (total <= NB_C) begin
                                state   <= IDLE;
                                hdr_rdy <= 1'b1;
                            end else begin
                                rem_len <= total - NB_C;
                                state   <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (slot_rdy) begin
                        state   <= IDLE;
                        hdr_rdy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_insert_hdr_out_reg #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (beat_vld),
        .in_data   (beat_data),
        .in_keep   (beat_keep),
        .in_last   (beat_last),
        .in_ready  (slot_rdy),
        .out_valid (bus.valid_out),
        .out_data  (bus.data_out),
        .out_keep  (bus.keep_out),
        .out_last  (bus.last_out),
        .out_ready (bus.ready_out)
    );

`ifdef AXIS_INSERT_HDR_ASSERT_EN
    logic [MAX_BYTES-1:0]    keep_in_exp;
    logic [DATA_BYTE_WD-1:0] keep_ins_exp;
    int                      hdr_h;

    // Reference byte enables for the protocol checks below.
    always_comb begin
        keep_in_exp  = cnt2keep_msb(keep2cnt(MAX_BYTES'(bus.keep_in)), DATA_BYTE_WD);
        hdr_h        = (bus.byte_insert_cnt == '0) ? DATA_BYTE_WD : int'(bus.byte_insert_cnt);
        keep_ins_exp = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i < hdr_h) keep_ins_exp[i] = 1'b1;
        end
    end

    a_keep_in: assert property (@(posedge clk) disable iff (rst)
        bus.valid_in |-> (bus.last_in ? (bus.keep_in == keep_in_exp[DATA_BYTE_WD-1:0]) : (&bus.keep_in)));
    a_keep_insert: assert property (@(posedge clk) disable iff (rst)
        bus.valid_insert |-> (bus.keep_insert == keep_ins_exp));
    a_in_stable: assert property (@(posedge clk) disable iff (rst)
        bus.valid_in && !bus.ready_in |=> bus.valid_in && $stable(bus.data_in));
    a_insert_stable: assert property (@(posedge clk) disable iff (rst)
        bus.valid_insert && !bus.ready_insert |=> bus.valid_insert && $stable(bus.data_insert));
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        bus.valid_out && !bus.ready_out |=> $stable(bus.data_out) && $stable(bus.keep_out) && $stable(bus.last_out));
`endif

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header (32-bit beats).
module tb_axi_stream_insert_header;
    localparam int DATA_WD = 32;
    localparam int TMO     = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    axis_insert_hdr_if #(.DATA_WD(DATA_WD)) bus();

    axi_stream_insert_header #(.DATA_WD(DATA_WD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Record every output handshake as {last, keep, data}.
    always @(negedge clk) begin
        if (!rst && bus.valid_out && bus.ready_out)
            got_q.push_back({27'b0, bus.last_out, bus.keep_out, bus.data_out});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({27'b0, l, k, d});
    endtask

    task automatic send_hdr(input logic [31:0] d, input logic [3:0] k, input logic [1:0] c);
        int cyc;
        @(posedge clk); #1;
        bus.valid_insert    = 1'b1;
        bus.data_insert     = d;
        bus.keep_insert     = k;
        bus.byte_insert_cnt = c;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.ready_insert) break;
            if (++cyc >= TMO) begin
                check("hdr_timeout", {63'b0, bus.ready_insert}, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int cyc;
        @(posedge clk); #1;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.ready_in) break;
            if (++cyc >= TMO) begin
                check("data_timeout", {63'b0, bus.ready_in}, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic check_beats(input string name);
        int cyc;
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_b%0d", name, i), got_q[i], exp_q[i]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_in        = 1'b0;
        bus.data_in         = '0;
        bus.keep_in         = '0;
        bus.last_in         = 1'b0;
        bus.ready_out       = 1'b1;
        bus.valid_insert    = 1'b0;
        bus.data_insert     = '0;
        bus.keep_insert     = '0;
        bus.byte_insert_cnt = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out",    {63'b0, bus.valid_out}, 64'd0);
        check("rst_data_out",     64'(bus.data_out), 64'd0);
        check("rst_keep_out",     64'(bus.keep_out), 64'd0);
        check("rst_last_out",     {63'b0, bus.last_out}, 64'd0);
        check("rst_ready_in",     {63'b0, bus.ready_in}, 64'd0);
        check("rst_ready_insert", {63'b0, bus.ready_insert}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // H=3, two payload beats, one residue byte
        send_hdr(32'hAABBCC00, 4'b0111, 2'd3);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hC, 1'b1);
        expect_beat(32'hBBCC0001, 4'hF, 1'b0);
        expect_beat(32'h02030405, 4'hF, 1'b0);
        expect_beat(32'h06000000, 4'h8, 1'b1);
        check_beats("h3_flush");

        // H=1, single beat exactly filling the word
        send_hdr(32'hAABBCC11, 4'b0001, 2'd1);
        send_beat(32'h01020304, 4'hE, 1'b1);
        expect_beat(32'h11010203, 4'hF, 1'b1);
        check_beats("h1_single");

        // H=2, short single beat, no flush
        send_hdr(32'h0000CC11, 4'b0011, 2'd2);
        send_beat(32'h01020304, 4'h8, 1'b1);
        expect_beat(32'hCC110100, 4'hE, 1'b1);
        check_beats("h2_short");

        // H=4 (cnt 0): full header beat, payload passes through aligned
        send_hdr(32'hDEADBEEF, 4'hF, 2'd0);
        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hC, 1'b1);
        expect_beat(32'hDEADBEEF, 4'hF, 1'b0);
        expect_beat(32'h11223344, 4'hF, 1'b0);
        expect_beat(32'h55660000, 4'hC, 1'b1);
        check_beats("h4_pass");

        // Backpressure: output held, payload stalled for 3 cycles
        send_hdr(32'hAABBCC00, 4'b0111, 2'd3);
        bus.ready_out = 1'b0;
        fork
            begin
                send_beat(32'h01020304, 4'hF, 1'b0);
                send_beat(32'h05060708, 4'hF, 1'b0);
                send_beat(32'h090A0B0C, 4'h8, 1'b1);
            end
            begin
                int cyc;
                cyc = 0;
                while (!bus.valid_out && cyc < TMO) begin
                    @(negedge clk);
                    cyc++;
                end
                check("bp_valid", {63'b0, bus.valid_out}, 64'd1);
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("bp_hold_data%0d", i), 64'(bus.data_out), 64'h0000_0000_BBCC_0001);
                    check($sformatf("bp_hold_rdyin%0d", i), {63'b0, bus.ready_in}, 64'd0);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                bus.ready_out = 1'b1;
            end
        join
        expect_beat(32'hBBCC0001, 4'hF, 1'b0);
        expect_beat(32'h02030405, 4'hF, 1'b0);
        expect_beat(32'h06070809, 4'hF, 1'b1);
        check_beats("bp");

        // Data before header, then two headers back to back
        fork
            begin
                send_beat(32'h01020304, 4'hE, 1'b1);
                send_beat(32'h01020304, 4'h8, 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check($sformatf("early_rdyin%0d", i), {63'b0, bus.ready_in}, 64'd0);
                end
                send_hdr(32'hAABBCC11, 4'b0001, 2'd1);
                @(negedge clk);
                check("hdr2_stall", {63'b0, bus.ready_insert}, 64'd0);
                send_hdr(32'h0000CC11, 4'b0011, 2'd2);
            end
        join
        expect_beat(32'h11010203, 4'hF, 1'b1);
        expect_beat(32'hCC110100, 4'hE, 1'b1);
        check_beats("b2b");

        // Reset mid-packet, then a clean packet
        send_hdr(32'hAABBCC00, 4'b0111, 2'd3);
        send_beat(32'h01020304, 4'hF, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid_out", {63'b0, bus.valid_out}, 64'd0);
        check("mid_rst_ready_in",  {63'b0, bus.ready_in}, 64'd0);
        check("mid_rst_ready_ins", {63'b0, bus.ready_insert}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready_ins", {63'b0, bus.ready_insert}, 64'd1);
        got_q.delete();
        exp_q.delete();
        send_hdr(32'hAABBCC11, 4'b0001, 2'd1);
        send_beat(32'h01020304, 4'hE, 1'b1);
        expect_beat(32'h11010203, 4'hF, 1'b1);
        check_beats("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_stream_insert_header.md
Name: axi_stream_insert_header

Overview:
- Prepends a variable-length header (1..DATA_BYTE_WD bytes) to each AXI-Stream packet and re-packs header plus payload into full-width beats.
- Sits between a payload source and a downstream AXI-Stream sink; the header arrives on a separate handshaked side channel, one header per packet.
- Byte order is big-endian: byte DATA_BYTE_WD-1 (MSB) is the first byte on the wire.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  payload beat valid.
- data_in  in  DATA_WD  payload data.
- keep_in  in  DATA_BYTE_WD  payload byte enables: all ones except on the last beat, where ones are contiguous from the MSB.
- last_in  in  1  last payload beat of the packet.
- ready_in  out  1  payload ready.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  output data.
- keep_out  out  DATA_BYTE_WD  output byte enables, MSB-aligned.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream ready.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header word; valid bytes are LSB-aligned.
- keep_insert  in  DATA_BYTE_WD  header byte enables (LSB-aligned ones).
- byte_insert_cnt  in  BYTE_CNT_WD  header byte count H; the value 0 means DATA_BYTE_WD.
- ready_insert  out  1  header ready.

Interface (already decided): one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=0. Reset mid-packet discards all state and the residue.
- States:
  - IDLE: ready_insert=1, ready_in=0. On valid_insert&&ready_insert, load carry = low H bytes of data_insert and latch H; go to STREAM.
  - STREAM: ready_insert=0, ready_in = !valid_out || ready_out.
  - FLUSH: ready_in=0, ready_insert=0.
- Beat formation in STREAM. For each accepted data beat (valid_in&&ready_in):
  - Output beat registered next cycle: data_out = {carry (H bytes), top DATA_BYTE_WD-H bytes of data_in}.
  - carry <= low H bytes of data_in.
  - Latency is 1 cycle.
- Last beat, with D = popcount(keep_in) and T = H+D:
  - T <= DATA_BYTE_WD: single beat, keep_out = T MSB ones, last_out=1, then IDLE.
  - Otherwise: full beat (keep all ones, last_out=0), then FLUSH emits the residue. Residue data_out = T-DATA_BYTE_WD carry bytes at the MSB, zeros below; keep_out = that many MSB ones; last_out=1. Then IDLE.
- Unused data_out bytes are 0.
- Output register: holds data_out/keep_out/last_out/valid_out stable while valid_out && !ready_out. A new beat may load in the same cycle the current one is consumed (full throughput).
- Header and data valid at once in IDLE: only the header is accepted; data is accepted from the next cycle.
- Header presented during STREAM/FLUSH waits (ready_insert=0) until IDLE.
- Data presented before a header stalls (ready_in=0).
- Single-beat packets (last_in on the first beat) are legal.
- A H=DATA_BYTE_WD header emits one full header beat ahead of the payload (data passes through aligned).

Optional Feature:
- Macro AXIS_INSERT_HDR_ASSERT_EN. When defined, compiles simulation assertions:
  - keep_in is MSB-contiguous on the last beat and all ones otherwise.
  - keep_insert equals H LSB ones.
  - valid_in/data_in stay stable until ready_in; valid_insert/data_insert stay stable until ready_insert.
  - data_out/keep_out/last_out stay stable while valid_out && !ready_out.
- When undefined, no checks exist and the RTL is functionally identical.

Decomposition:
- Package axis_insert_hdr_pkg:
  - state enum {IDLE, STREAM, FLUSH}.
  - Functions keep2cnt (popcount of MSB-aligned keep) and cnt2keep_msb (count to MSB-aligned keep).
- One sub-module, axis_insert_hdr_out_reg: a valid/ready output register slice carrying data, keep, last.

Test Plan:
- Header 0xAABBCC00, keep 0111, cnt 3; data 0x01020304 (keep f), then 0x05060708 last keep 1100 -> outputs 0xBBCC0001 f, 0x02030405 f, 0x06000000 keep 1000 last.
- Header 0xAABBCC11, cnt 1; data 0x01020304 last keep 1110 -> single beat 0x11010203 keep f last.
- Header cnt 2 (bytes 0xCC11); data 0x01020304 last keep 1000 -> 0xCC110100 keep 1110 last, no flush beat.
- ready_out low for 3 cycles mid-packet -> data_out held stable, ready_in=0, no beat lost or duplicated.
- Data valid before header, then two headers back-to-back -> ready_in=0 until header taken; second header stalls until the first packet's last_out handshake.
- Reset asserted mid-packet -> next cycle valid_out=0, ready_insert=1 after reset release; the next packet is correct.
